// File: rtl/systolic_array_out_fifo.sv
// Collects elements leaving a systolic array edge into full rows and holds each
// completed row for a valid/ready consumer, so the next row can be gathered meanwhile.

module sys_out_slot #(
    parameter int DW  = 16,
    parameter int CW  = 3,
    parameter int IDX = 0
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          accept,
    input  logic [CW-1:0] elem_count,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            q <= '0;
        else if (accept && elem_count == CW'(IDX))
            q <= d;
    end
endmodule

module systolic_array_out_fifo #(
    parameter int DW = 16,
    parameter int N  = 4
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 shift,
    input  logic [DW-1:0]        in_value,
    output logic                 in_ready,
    input  logic                 clear,
    output logic                 row_valid,
    input  logic                 row_ready,
    output logic [DW*N-1:0]      row_values,
    output logic [$clog2(N):0]   elem_count
);
    localparam int CW = $clog2(N) + 1;

    logic [N-2:0][DW-1:0] acc;
    logic [N-1:0][DW-1:0] row_q;
    logic [CW-1:0]        cnt_q;
    logic                 vld_q;
    logic                 last_elem;
    logic                 accept;
    logic                 complete;

    assign last_elem = (cnt_q == CW'(N - 1));
    // Only the final element of a row can stall, and only behind an unconsumed held row.
    assign in_ready  = !(last_elem && vld_q && !row_ready);
    assign accept    = shift && in_ready && !clear;
    assign complete  = accept && last_elem;

    genvar k;
    generate
        for (k = 0; k < N - 1; k++) begin : g_slot
            sys_out_slot #(.DW(DW), .CW(CW), .IDX(k)) u_slot (
                .CLK        (CLK),
                .nRST       (nRST),
                .accept     (accept),
                .elem_count (cnt_q),
                .d          (in_value),
                .q          (acc[k])
            );
        end
    endgenerate

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q <= '0;
            vld_q <= 1'b0;
            row_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
            vld_q <= 1'b0;
        end else begin
            if (accept)
                cnt_q <= last_elem ? '0 : cnt_q + 1'b1;
            // A completion in the same cycle as a drain keeps the row valid with new data.
            if (complete) begin
                vld_q <= 1'b1;
                row_q <= {in_value, acc};
            end else if (row_ready) begin
                vld_q <= 1'b0;
            end
        end
    end

    assign row_valid  = vld_q;
    assign row_values = row_q;
    assign elem_count = cnt_q;
endmodule

// File: doc/systolic_array_out_fifo.md
SYSTOLIC_ARRAY_OUT_FIFO -- requirements
Module: systolic_array_out_fifo

Interface
REQ-001: The block SHALL have parameter DW, default 16, bit width of one array element (matches sys_arr_pkg DW).
REQ-002: The block SHALL have parameter N, default 4, elements per row (matches sys_arr_pkg N); N >= 2.
REQ-003: The block SHALL have port CLK, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004: The block SHALL have port nRST, input, 1 bit, reset; asynchronous and active-low.
REQ-005: The block SHALL have port shift, input, 1 bit, an array element is presented on in_value this cycle.
REQ-006: The block SHALL have port in_value, input, DW bits, the element leaving the array edge.
REQ-007: The block SHALL have port in_ready, output, 1 bit, the block can accept a shift this cycle.
REQ-008: The block SHALL have port clear, input, 1 bit, synchronous discard of all partial and held data.
REQ-009: The block SHALL have port row_valid, output, 1 bit, a complete row is held on row_values.
REQ-010: The block SHALL have port row_ready, input, 1 bit, the consumer takes the held row this cycle.
REQ-011: The block SHALL have port row_values, output, DW*N bits, the assembled row; element k is at [DW*(k+1)-1 : DW*k].
REQ-012: The block SHALL have port elem_count, output, $clog2(N)+1 bits, number of elements in the partial row (0..N-1).

Function
REQ-013: A shift SHALL be accepted iff shift=1 and in_ready=1 and clear=0; a non-accepted shift changes no state.
REQ-014: The k-th accepted shift of a row (k = 0..N-1) SHALL place in_value into element k; the first value out of the array lands in element 0.
REQ-015: On an accepted shift with elem_count < N-1, the block SHALL store the element and increment elem_count by 1.
REQ-016: On an accepted shift with elem_count = N-1, the block SHALL copy the completed row (elements 0..N-2 from the accumulator, element N-1 from in_value) into the holding register, set row_valid=1 and reset elem_count to 0, all in the same edge.
REQ-017: row_valid SHALL assert on the first edge after the N-th accepted shift; latency from the last element to row_valid is 1 cycle.
REQ-018: A row handshake SHALL occur when row_valid=1 and row_ready=1; row_valid then deasserts on the next edge unless REQ-019 applies.
REQ-019: If a row handshake and a row completion happen in the same cycle, row_valid SHALL stay 1 and row_values SHALL take the new row.
REQ-020: in_ready SHALL be 0 only when elem_count = N-1 and row_valid=1 and row_ready=0; it SHALL be 1 otherwise, including during accumulation while a row is held.
REQ-021: in_ready MAY depend combinationally on row_ready; no other combinational path from input to output is permitted.
REQ-022: row_values SHALL remain stable while row_valid=1 and row_ready=0.
REQ-023: row_values SHALL keep its last value after a handshake until the next row completes, but it is don't-care while row_valid=0.
REQ-024: When clear=1 the block SHALL set elem_count=0 and row_valid=0 on the next edge, and ignore shift and row completion in that cycle; clear has priority over all other events.
REQ-025: row_ready while row_valid=0 SHALL have no effect.

Reset
REQ-026: While nRST=0, the block SHALL force elem_count=0, row_valid=0, row_values=0 and all accumulator elements to 0, independent of CLK.
REQ-027: Reset asserted mid-row or with a held row SHALL discard the data; after release, the next accepted shift is element 0.
REQ-028: in_ready SHALL be 1 during and immediately after reset.

Verification (DW=16, N=4)
REQ-029: The bench SHALL cover the basic row: shift 0x0001,0x0002,0x0003,0x0004 on consecutive cycles with row_ready=1 -> row_valid=1 the cycle after the 4th shift with row_values=0x0004_0003_0002_0001, then 0 the following cycle.
REQ-030: The bench SHALL cover backpressure: with row_ready=0, complete row A, then shift 3 elements of row B -> in_ready=0 with elem_count=3 and row_values still equal to A; raising row_ready -> in_ready=1 in the same cycle, and the 4th shift of B is accepted.
REQ-031: The bench SHALL cover simultaneous drain and complete: hold row A, then assert row_ready in the same cycle as the 4th shift of B -> row_valid stays 1 and row_values=B on the next edge.
REQ-032: The bench SHALL cover clear priority: after 2 shifts, assert clear and shift together -> elem_count=0, row_valid=0; the next 4 shifts form a row whose element 0 is the first post-clear value.
REQ-033: The bench SHALL cover asynchronous reset: drop nRST between edges with a held row and elem_count=2 -> row_valid=0, elem_count=0 and row_values=0 immediately, without waiting for a clock edge.
REQ-034: The bench SHALL cover gapped input: shift with shift=0 idle cycles between elements -> the row is identical to the back-to-back case, and idle cycles do not change elem_count.
